dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache. It is the responder on the 8-bit CPU data-memory port (READ/WRITE/ADDRESS/WRITEDATA → READDATA/BUSYWAIT) and stalls the CPU through BUSYWAIT. On a miss it fetches a 4-byte block from main memory over a 32-bit block interface, and writes the old block back first when that block is dirty.

## Interface
- No parameters. Geometry is fixed: 8 blocks × 4 bytes; ADDRESS = tag[7:5], index[4:2], offset[1:0].
- CLK  in  1  clock
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK
- READ  in  1  CPU byte read request
- WRITE  in  1  CPU byte write request
- ADDRESS  in  8  CPU byte address
- WRITEDATA  in  8  CPU store data
- READDATA  out  8  byte at {index, offset}; valid on a read hit
- BUSYWAIT  out  1  stall to CPU
- MEM_READ  out  1  block read request to main memory
- MEM_WRITE  out  1  block write request to main memory
- MEM_ADDRESS  out  6  block address {tag, index}
- MEM_WRITEDATA  out  32  write-back block; byte 0 at [7:0]
- MEM_READDATA  in  32  fetched block; byte 0 at [7:0]
- MEM_BUSYWAIT  in  1  main memory busy

## Operation
- Storage: data[8][32], tag[8][3], valid[8], dirty[8].
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, no request: BUSYWAIT = 0.
- IDLE, READ & hit: BUSYWAIT = 0. READDATA = data[index][8·offset +: 8], combinational from ADDRESS.
- IDLE, WRITE & hit: BUSYWAIT = 0. At the next posedge, WRITEDATA is stored into the selected byte and dirty[index] is set to 1.
- IDLE, request & miss: BUSYWAIT = 1 combinationally. At the next posedge the state moves to WRITEBACK if valid[index] & dirty[index], otherwise to FETCH.
- WRITEBACK:
  - Drives MEM_WRITE = 1, MEM_ADDRESS = {tag[index], index}, MEM_WRITEDATA = data[index].
  - Moves to FETCH at the first posedge where MEM_BUSYWAIT = 0, once at least one full cycle has been spent in the state.
- FETCH:
  - Drives MEM_READ = 1, MEM_ADDRESS = {ADDRESS[7:5], index}.
  - Captures MEM_READDATA and moves to UPDATE at the first posedge where MEM_BUSYWAIT = 0, under the same one-cycle minimum.
- UPDATE (one cycle):
  - Sets data[index] = fetched block, tag[index] = ADDRESS[7:5], valid = 1, dirty = 0.
  - Moves to IDLE, where the pending access is re-evaluated as a hit (read returns the byte; write merges and sets dirty).
- BUSYWAIT = 1 in every state other than IDLE.
- READ and WRITE asserted together: treated as WRITE.
- ADDRESS, READ and WRITE are held stable by the CPU while BUSYWAIT = 1. A change in them during a miss is unsupported.
- Main-memory contract:
  - Main memory raises MEM_BUSYWAIT within the first cycle of a request and drops it when the transfer is complete.
  - The cache deasserts MEM_READ/MEM_WRITE on the cycle after it sees completion.
- In IDLE and UPDATE: MEM_READ = 0 and MEM_WRITE = 0. MEM_ADDRESS and MEM_WRITEDATA are don't-care.

## Timing
- Reset (posedge with RESET = 1): state = IDLE, all valid/dirty/tag/data cleared to 0.
  - Outputs after reset: BUSYWAIT = 0, MEM_READ = 0, MEM_WRITE = 0, MEM_ADDRESS = 0, MEM_WRITEDATA = 0, READDATA = 0.
- Reset mid-miss: the transaction is abandoned, requests drop after that edge, and dirty data is discarded.
- Read hit: 0 stall cycles; READDATA is combinational.
- Write hit: 0 stall cycles; data commits at the posedge where the CPU advances.
- Clean miss with main-memory busy of L cycles (L ≥ 1): BUSYWAIT high for 1 (IDLE) + L (FETCH) + 1 (UPDATE) cycles, then low in IDLE as a hit.
- Dirty miss: an additional L_w cycles for WRITEBACK, before FETCH.
- The state register, arrays and the fetch capture all update on posedge CLK only.

## Test plan
- Reset, then READ ADDRESS=8'h00 (cold miss) with memory L=5 returning 32'h44332211 -> MEM_READ with MEM_ADDRESS=6'h00; BUSYWAIT high 7 cycles; then READDATA=8'h11, and ADDRESS=8'h03 hits with READDATA=8'h44.
- WRITE 8'hAB to 8'h05 after block 1 has been fetched -> no stall; dirty[1]=1; a subsequent READ 8'h05 gives 8'hAB with 0 stall.
- With the state above, READ 8'h25 (same index, tag 1) -> WRITEBACK with MEM_ADDRESS=6'h01 and byte 1 of MEM_WRITEDATA = 8'hAB, then FETCH with MEM_ADDRESS=6'h09; dirty[1]=0 afterwards.
- READ and WRITE both asserted on a hit -> behaves as a write; READDATA is not relied upon.
- RESET asserted during FETCH -> MEM_READ and BUSYWAIT are 0 after that edge; the next access to the same address misses.
- Miss on a clean block (valid, dirty=0) -> no MEM_WRITE cycle; goes directly to FETCH.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: 8 blocks of 4 bytes.
// Stalls the CPU on a miss while it writes back a dirty victim and fetches the new block.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_UPDATE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q [8];
  logic [2:0]  tag_q  [8];
  logic [7:0]  valid_q, dirty_q;
  logic [31:0] fetch_q;

  logic [2:0] addr_tag, addr_idx;
  logic [1:0] addr_off;
  logic       req, hit, write_hit;

  assign addr_tag  = ADDRESS[7:5];
  assign addr_idx  = ADDRESS[4:2];
  assign addr_off  = ADDRESS[1:0];
  assign req       = READ | WRITE;
  assign hit       = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
  assign write_hit = (state_q == S_IDLE) & WRITE & hit;

  assign READDATA = data_q[addr_idx][{addr_off, 3'b000} +: 8];

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (req && !hit)
          state_d = (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: if (!MEM_BUSYWAIT) state_d = S_FETCH;
      S_FETCH:     if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      S_UPDATE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT      = 1'b1;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    case (state_q)
      S_IDLE: BUSYWAIT = req & ~hit;
      S_WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[addr_idx], addr_idx};
        MEM_WRITEDATA = data_q[addr_idx];
      end
      S_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_idx};
      end
      default: ;
    endcase
  end

  // Storage: byte merge on a write hit, whole-block refill in UPDATE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= 32'd0;
        tag_q[i]  <= 3'd0;
      end
      valid_q <= 8'd0;
      dirty_q <= 8'd0;
      fetch_q <= 32'd0;
    end else begin
      if (state_q == S_FETCH && !MEM_BUSYWAIT)
        fetch_q <= MEM_READDATA;
      if (write_hit) begin
        data_q[addr_idx][{addr_off, 3'b000} +: 8] <= WRITEDATA;
        dirty_q[addr_idx] <= 1'b1;
      end else if (state_q == S_UPDATE) begin
        data_q[addr_idx]  <= fetch_q;
        tag_q[addr_idx]   <= addr_tag;
        valid_q[addr_idx] <= 1'b1;
        dirty_q[addr_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed vector table, reset corner sequences and randomized
// accesses checked against an abstract cache/memory model.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'd0, WRITEDATA = 8'd0;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  logic        MEM_BUSYWAIT;

  dcache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i * 4);
    if (i == 0) return 32'h44332211;
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Main memory: busy for lat-1 cycles from the start of each transfer,
  // completes at the first edge where busy is low.
  logic [31:0] mem [64];
  int          cnt = 0;
  int          latw = 1, latf = 1;
  bit          load = 1'b0;

  assign MEM_READDATA = mem[MEM_ADDRESS];

  always_comb begin
    MEM_BUSYWAIT = 1'b0;
    if (MEM_READ || MEM_WRITE)
      MEM_BUSYWAIT = (cnt < ((MEM_WRITE ? latw : latf) - 1));
  end

  always @(posedge CLK) begin
    if (load)
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    if (RESET || !(MEM_READ || MEM_WRITE)) cnt <= 0;
    else if (!MEM_BUSYWAIT) begin
      cnt <= 0;
      if (MEM_WRITE && !load) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
    end else cnt <= cnt + 1;
  end

  // Abstract model: cache lines and main memory as plain arrays.
  bit          mv [8];
  bit          md [8];
  logic [2:0]  mt [8];
  logic [31:0] mdat [8];
  logic [31:0] mmem [64];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 0; md[i] = 0; mt[i] = 3'd0; mdat[i] = 32'd0;
    end
  endtask

  task automatic predict(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int lw, input int lf, output int stall, output logic [7:0] rdata,
                         output bit wb, output logic [5:0] wba, output logic [31:0] wbd,
                         output logic [5:0] fa);
    int idx, off;
    idx = int'(a[4:2]); off = int'(a[1:0]);
    stall = 0; wb = 0; wba = 6'd0; wbd = 32'd0; fa = 6'd0; rdata = 8'd0;
    if (!(mv[idx] && mt[idx] == a[7:5])) begin
      wb = mv[idx] && md[idx];
      if (wb) begin
        wba = {mt[idx], a[4:2]};
        wbd = mdat[idx];
        mmem[wba] = mdat[idx];
      end
      fa = {a[7:5], a[4:2]};
      mdat[idx] = mmem[fa];
      mt[idx] = a[7:5]; mv[idx] = 1; md[idx] = 0;
      stall = 2 + lf + (wb ? lw : 0);
    end
    if (w) begin
      mdat[idx][off*8 +: 8] = d;
      md[idx] = 1;
    end else if (r) rdata = mdat[idx][off*8 +: 8];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; load = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'd0; WRITEDATA = 8'd0;
    @(negedge CLK);
    load = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 64; i++) mmem[i] = pat(i);
    model_reset();
  endtask

  task automatic access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input int lw, input int lf, output int stall, output logic [7:0] rdata,
                        output bit wb, output logic [5:0] wba, output logic [31:0] wbd,
                        output bit fs, output logic [5:0] fa);
    @(negedge CLK);
    READ = r; WRITE = w; ADDRESS = a; WRITEDATA = d; latw = lw; latf = lf;
    #1;
    stall = 0; wb = 0; wba = 6'd0; wbd = 32'd0; fs = 0; fa = 6'd0;
    while (BUSYWAIT && stall < 100) begin
      if (MEM_WRITE) begin wb = 1; wba = MEM_ADDRESS; wbd = MEM_WRITEDATA; end
      if (MEM_READ)  begin fs = 1; fa = MEM_ADDRESS; end
      @(negedge CLK); #1;
      stall++;
    end
    rdata = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  typedef struct {
    bit rd; bit wr; logic [7:0] addr; logic [7:0] wdata; int latw; int latf;
    int stall; logic [7:0] rdata; bit wb; logic [5:0] wbaddr; logic [31:0] wbdata; logic [5:0] faddr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int stall, estall;
    logic [7:0] rdata, erdata;
    bit wb, ewb, fs;
    logic [5:0] wba, ewba, fa, efa;
    logic [31:0] wbd, ewbd;
    bit r, w;
    logic [7:0] a, d;
    int lw, lf, op;

    tbl[0]  = '{1, 0, 8'h00, 8'h00, 1, 5, 7, 8'h11, 0, 6'h00, 32'h0, 6'h00};
    tbl[1]  = '{1, 0, 8'h03, 8'h00, 1, 1, 0, 8'h44, 0, 6'h00, 32'h0, 6'h00};
    tbl[2]  = '{1, 0, 8'h04, 8'h00, 1, 3, 5, 8'h04, 0, 6'h00, 32'h0, 6'h01};
    tbl[3]  = '{0, 1, 8'h05, 8'hAB, 1, 1, 0, 8'h00, 0, 6'h00, 32'h0, 6'h00};
    tbl[4]  = '{1, 0, 8'h05, 8'h00, 1, 1, 0, 8'hAB, 0, 6'h00, 32'h0, 6'h00};
    tbl[5]  = '{1, 0, 8'h25, 8'h00, 2, 4, 8, 8'h25, 1, 6'h01, 32'h0706AB04, 6'h09};
    tbl[6]  = '{1, 0, 8'h05, 8'h00, 1, 3, 5, 8'hAB, 0, 6'h00, 32'h0, 6'h01};
    tbl[7]  = '{1, 1, 8'h06, 8'h5A, 1, 1, 0, 8'h00, 0, 6'h00, 32'h0, 6'h00};
    tbl[8]  = '{1, 0, 8'h06, 8'h00, 1, 1, 0, 8'h5A, 0, 6'h00, 32'h0, 6'h00};
    tbl[9]  = '{0, 1, 8'h41, 8'h42, 1, 2, 4, 8'h00, 0, 6'h00, 32'h0, 6'h10};
    tbl[10] = '{1, 0, 8'h41, 8'h00, 1, 1, 0, 8'h42, 0, 6'h00, 32'h0, 6'h00};
    tbl[11] = '{1, 0, 8'h00, 8'h00, 1, 1, 4, 8'h11, 1, 6'h10, 32'h43424240, 6'h00};
    tbl[12] = '{1, 0, 8'h07, 8'h00, 1, 1, 0, 8'h07, 0, 6'h00, 32'h0, 6'h00};

    do_reset();
    #1;
    chk("reset BUSYWAIT", 32'(BUSYWAIT), 32'd0);
    chk("reset MEM_READ", 32'(MEM_READ), 32'd0);
    chk("reset MEM_WRITE", 32'(MEM_WRITE), 32'd0);
    chk("reset MEM_ADDRESS", 32'(MEM_ADDRESS), 32'd0);
    chk("reset MEM_WRITEDATA", MEM_WRITEDATA, 32'd0);
    chk("reset READDATA", 32'(READDATA), 32'd0);

    for (int i = 0; i < 13; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].latw, tbl[i].latf,
             stall, rdata, wb, wba, wbd, fs, fa);
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'(tbl[i].stall));
      chk($sformatf("vec%0d writeback", i), 32'(wb), 32'(tbl[i].wb));
      if (tbl[i].wb) begin
        chk($sformatf("vec%0d wb addr", i), 32'(wba), 32'(tbl[i].wbaddr));
        chk($sformatf("vec%0d wb data", i), wbd, tbl[i].wbdata);
      end
      if (tbl[i].stall > 0) chk($sformatf("vec%0d fetch addr", i), 32'(fa), 32'(tbl[i].faddr));
      if (tbl[i].rd && !tbl[i].wr) chk($sformatf("vec%0d rdata", i), 32'(rdata), 32'(tbl[i].rdata));
    end

    // Reset in the middle of a fetch abandons the miss.
    do_reset();
    @(negedge CLK);
    latf = 6; READ = 1'b1; ADDRESS = 8'h00;
    @(negedge CLK); @(negedge CLK); #1;
    chk("midfetch MEM_READ before reset", 32'(MEM_READ), 32'd1);
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK); #1;
    chk("midfetch MEM_READ after reset", 32'(MEM_READ), 32'd0);
    chk("midfetch BUSYWAIT after reset", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    access(1, 0, 8'h00, 8'h00, 1, 2, stall, rdata, wb, wba, wbd, fs, fa);
    chk("after midfetch reset stall", 32'(stall), 32'd4);
    chk("after midfetch reset rdata", 32'(rdata), 32'h11);

    // Dirty data is discarded by reset: no writeback afterwards.
    access(0, 1, 8'h01, 8'h77, 1, 1, stall, rdata, wb, wba, wbd, fs, fa);
    chk("dirty write hit stall", 32'(stall), 32'd0);
    do_reset();
    access(1, 0, 8'h21, 8'h00, 1, 2, stall, rdata, wb, wba, wbd, fs, fa);
    chk("discard no writeback", 32'(wb), 32'd0);
    chk("discard stall", 32'(stall), 32'd4);
    access(1, 0, 8'h01, 8'h00, 1, 1, stall, rdata, wb, wba, wbd, fs, fa);
    chk("discard memory intact", 32'(rdata), 32'h22);

    // Randomized accesses against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 2));
      r  = (op != 1);
      w  = (op != 0);
      a  = 8'($urandom_range(0, 255));
      d  = 8'($urandom_range(0, 255));
      lw = int'($urandom_range(1, 4));
      lf = int'($urandom_range(1, 4));
      predict(r, w, a, d, lw, lf, estall, erdata, ewb, ewba, ewbd, efa);
      access(r, w, a, d, lw, lf, stall, rdata, wb, wba, wbd, fs, fa);
      chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(estall));
      chk($sformatf("rnd%0d writeback", n), 32'(wb), 32'(ewb));
      if (ewb) begin
        chk($sformatf("rnd%0d wb addr", n), 32'(wba), 32'(ewba));
        chk($sformatf("rnd%0d wb data", n), wbd, ewbd);
      end
      if (estall > 0) chk($sformatf("rnd%0d fetch addr", n), 32'(fa), 32'(efa));
      if (r && !w) chk($sformatf("rnd%0d rdata", n), 32'(rdata), 32'(erdata));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
